mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- CPU-side load/store sequencer sitting directly upstream of the 12-bit byte-addressed data memory.
- Accepts one request at a time from the datapath via a valid/ready handshake.
- Drives the memory's Memread/Memwrite/Addrin and its 32-bit data bus for a fixed, phase-aligned access window.
- Returns load data extended per opcode, with a one-cycle response pulse.

Parameters:
- ACC_CYCLES, 4: clocks per memory access window; must be even and ≥2.
- ADDR_W, 12: memory byte-address width.

Ports:
- clk  in  1  system clock, shared with the memory.
- rst  in  1  synchronous active-high reset, shared with the memory.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  3  operation code: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SB uses [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected: illegal op, or address above range.
- Memread  out  1  to memory: memory drives the bus.
- Memwrite  out  2  to memory: 0 idle, 1 word store, 3 byte store.
- Addrin  out  12  to memory byte address.
- bus_dout  out  32  store data toward the bus.
- bus_drive  out  1  bus output enable; top level ties BUS = bus_drive ? bus_dout : Z.
- bus_din  in  32  bus value as seen by this block.

Behaviour:
- **Reset values:** all outputs 0; state IDLE; phase 0; cnt 0; captured request fields 0.
- **phase register:** 0 in the first cycle after reset, toggles every clock. It mirrors the memory's internal half-select, so every window starts on phase 0.
- **States:** IDLE, ACCESS, DONE.
- **req_ready:** asserted iff state==IDLE && phase==1. It is combinational from registers, never from req_valid.
- **Accept (IDLE, req_valid && req_ready):**
  - Latch op, addr, and wdata.
  - If op==111 or addr[31:ADDR_W]!=0, go to DONE with err=1, without touching the memory.
  - Otherwise go to ACCESS with cnt=0.
- **ACCESS:**
  - All memory outputs are registered and held constant for exactly ACC_CYCLES clocks.
  - Addrin = addr[11:0].
  - Loads: Memread=1, Memwrite=0, bus_drive=0.
  - SW: Memwrite=1, bus_drive=1, bus_dout=wdata.
  - SB: Memwrite=3, bus_drive=1, bus_dout={24'b0, wdata[7:0]}.
  - cnt increments each clock. At cnt==ACC_CYCLES-1, register bus_din into the load-data holder, then go to DONE.
  - Memread, Memwrite, and bus_drive are deasserted on entry to DONE.
- **DONE:**
  - resp_valid=1 for exactly one cycle with resp_rdata and resp_err valid, then go to IDLE.
  - resp_valid, resp_rdata, and resp_err return to 0 the following cycle.
- **Load extension (bus data already byte-aligned by the memory):**
  - LW: full word.
  - LB: sign-extend [7:0].
  - LBU: zero-extend [7:0].
  - LH: sign-extend [15:0].
  - LHU: zero-extend [15:0].
- **Latency:**
  - Accept edge T: window covers cycles T+1..T+ACC_CYCLES, and resp_valid is high at T+ACC_CYCLES+1.
  - Error requests: resp_valid at T+1.
- **Phase boundary:** a request presented while phase==0 waits one cycle. req_valid must stay high with stable fields until accepted.
- **Ignored inputs:** req_valid is ignored in ACCESS and DONE. Changes to req_* after accept are ignored.
- **Back-to-back:** the next accept occurs at the first IDLE cycle with phase==1. Memread and Memwrite are never high in the same cycle.
- **Misalignment:** misaligned word addresses are passed through unchanged; the memory handles straddling. This is not an error.
- **Reset mid-operation:** rst in any state clears everything next edge. There is no resp_valid for the aborted request, and Memwrite and bus_drive are 0 from the next cycle.

Decomposition:
- **Package mem_pkg:**
  - Opcode constants OP_LW..OP_ILL.
  - MW_NONE=2'd0, MW_WORD=2'd1, MW_BYTE=2'd3.
  - ADDR_W.
  - State enum {IDLE, ACCESS, DONE}.
- **Sub-module load_extend:** combinational (op, raw[31:0]) -> extended[31:0]. It is reused by the future I/O path.

Test Plan:
- SW 0xDEADBEEF @0x004 then LW @0x004 -> Memwrite=1 for 4 clocks with bus_dout=0xDEADBEEF; the load returns resp_rdata=0xDEADBEEF, err=0, with resp_valid exactly ACC_CYCLES+1 cycles after accept.
- SB 0x80 @0x005, then LB @0x005 -> 0xFFFFFF80; LBU @0x005 -> 0x00000080; SB shows Memwrite=3 and bus_dout=0x00000080.
- LH of stored 0x0000F00D word @0x008 -> 0xFFFFF00D; LHU -> 0x0000F00D.
- LW @0x00001000 and op=111 -> resp_err=1 and resp_rdata=0 one cycle after accept; Memread/Memwrite never asserted.
- req_valid raised on a phase-0 cycle -> req_ready low that cycle, accept next cycle, first ACCESS cycle has phase 0; req_valid held through ACCESS causes no second access.
- rst asserted at cnt==1 of an SW -> Memwrite=0 and bus_drive=0 next cycle, no resp_valid, req_ready returns on the second cycle after rst drops.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared opcodes, memory-strobe encodings and FSM states for the
//            load/store sequencer.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_WORD = 2'd1;
  localparam logic [1:0] MW_BYTE = 2'd3;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_if
// Purpose  : CPU request/response handshake plus data-memory strobes and bus.
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              Memread;
  logic [1:0]        Memwrite;
  logic [ADDR_W-1:0] Addrin;
  logic [31:0]       bus_dout;
  logic              bus_drive;
  logic [31:0]       bus_din;

  // Environment side: CPU datapath plus the memory/bus fabric.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, bus_din,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  Memread, Memwrite, Addrin, bus_dout, bus_drive
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, bus_din,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output Memread, Memwrite, Addrin, bus_dout, bus_drive
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Sign/zero extension of byte-aligned load data by opcode.
// Revision : 1.0  initial release
// ============================================================================
module load_extend
  import mem_pkg::*;
(
  input  wire logic [2:0]  op,
  input  wire logic [31:0] raw,
  output logic      [31:0] extended
);

  always_comb begin
    extended = '0;
    case (op)
      OP_LW:   extended = raw;
      OP_LB:   extended = {{24{raw[7]}}, raw[7:0]};
      OP_LBU:  extended = {24'b0, raw[7:0]};
      OP_LH:   extended = {{16{raw[15]}}, raw[15:0]};
      OP_LHU:  extended = {16'b0, raw[15:0]};
      default: extended = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Single-outstanding load/store sequencer driving a phase-aligned
//            fixed-length access window into the byte-addressed data memory.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int ACC_CYCLES = 4,
  parameter int ADDR_W     = mem_pkg::ADDR_W
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_access_ctrl_if.slave mif
);

  import mem_pkg::*;

  localparam int              CNT_W      = (ACC_CYCLES > 2) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ACC_CYCLES - 1);

  state_t            r_state;
  logic              r_phase;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_memread;
  logic [1:0]        r_memwrite;
  logic [ADDR_W-1:0] r_addrin;
  logic [31:0]       r_bus_dout;
  logic              r_bus_drive;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  logic              w_req_ready;
  logic              w_req_bad;
  logic [31:0]       w_ext;

  // Acceptance only on phase 1 so the window always begins on the memory's phase 0.
  assign w_req_ready = (r_state == IDLE) && r_phase;
  assign w_req_bad   = (mif.req_op == OP_ILL) || (|mif.req_addr[31:ADDR_W]);

  load_extend u_load_extend (
    .op       (r_op),
    .raw      (mif.bus_din),
    .extended (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_phase      <= 1'b0;
      r_cnt        <= '0;
      r_op         <= '0;
      r_memread    <= 1'b0;
      r_memwrite   <= MW_NONE;
      r_addrin     <= '0;
      r_bus_dout   <= '0;
      r_bus_drive  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_phase <= ~r_phase;
      case (r_state)
        IDLE: begin
          if (mif.req_valid && w_req_ready) begin
            r_op <= mif.req_op;
            if (w_req_bad) begin
              r_state      <= DONE;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              // Address and store data are captured directly into the held bus outputs.
              r_state  <= ACCESS;
              r_cnt    <= '0;
              r_addrin <= mif.req_addr[ADDR_W-1:0];
              if (is_load(mif.req_op)) begin
                r_memread <= 1'b1;
              end else if (mif.req_op == OP_SW) begin
                r_memwrite  <= MW_WORD;
                r_bus_drive <= 1'b1;
                r_bus_dout  <= mif.req_wdata;
              end else begin
                r_memwrite  <= MW_BYTE;
                r_bus_drive <= 1'b1;
                r_bus_dout  <= {24'b0, mif.req_wdata[7:0]};
              end
            end
          end
        end

        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_CNT_LAST) begin
            r_state      <= DONE;
            r_memread    <= 1'b0;
            r_memwrite   <= MW_NONE;
            r_bus_drive  <= 1'b0;
            r_bus_dout   <= '0;
            r_addrin     <= '0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= is_load(r_op) ? w_ext : 32'h0;
          end
        end

        DONE: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign mif.req_ready  = w_req_ready;
  assign mif.resp_valid = r_resp_valid;
  assign mif.resp_rdata = r_resp_rdata;
  assign mif.resp_err   = r_resp_err;
  assign mif.Memread    = r_memread;
  assign mif.Memwrite   = r_memwrite;
  assign mif.Addrin     = r_addrin;
  assign mif.bus_dout   = r_bus_dout;
  assign mif.bus_drive  = r_bus_drive;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench with an emulated data memory and a byte-array
//            reference model of load/store results.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int ACC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(12)) mif ();

  mem_access_ctrl #(.ACC_CYCLES(ACC), .ADDR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Emulated memory: little-endian word read from Addrin, writes while strobed.
  logic [7:0]  emu_mem [4096];
  logic [11:0] ea1, ea2, ea3;
  assign ea1 = mif.Addrin + 12'd1;
  assign ea2 = mif.Addrin + 12'd2;
  assign ea3 = mif.Addrin + 12'd3;
  assign mif.bus_din = mif.Memread ?
      {emu_mem[ea3], emu_mem[ea2], emu_mem[ea1], emu_mem[mif.Addrin]} : 32'hA5A5_5A5A;

  initial begin
    for (int i = 0; i < 4096; i++) emu_mem[i] = 8'((i * 37 + 11) % 256);
    forever begin
      @(posedge clk);
      if (mif.Memwrite == 2'd1 && mif.bus_drive) begin
        emu_mem[mif.Addrin] <= mif.bus_dout[7:0];
        emu_mem[ea1]        <= mif.bus_dout[15:8];
        emu_mem[ea2]        <= mif.bus_dout[23:16];
        emu_mem[ea3]        <= mif.bus_dout[31:24];
      end else if (mif.Memwrite == 2'd3 && mif.bus_drive) begin
        emu_mem[mif.Addrin] <= mif.bus_dout[7:0];
      end
    end
  end

  // Reference model: what memory should contain, and what each load returns.
  int unsigned ref_mem [4096];

  function automatic int unsigned ref_word(input int unsigned a);
    return ref_mem[a % 4096] + 256 * ref_mem[(a + 1) % 4096]
         + 65536 * ref_mem[(a + 2) % 4096] + 16777216 * ref_mem[(a + 3) % 4096];
  endfunction

  function automatic logic [31:0] ref_ext(input int unsigned op, input int unsigned w);
    int unsigned b, h;
    b = w % 256;
    h = w % 65536;
    case (op)
      0: return w;
      1: return (b >= 128) ? b - 32'd256 : b;
      2: return b;
      3: return (h >= 32768) ? h - 32'd65536 : h;
      4: return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit phase0, input bit hold);
    bit          bad;
    int          w;
    int unsigned a;
    logic [31:0] exp_rdata, exp_dout;
    logic [1:0]  exp_mw;
    logic        exp_mr, exp_drv;
    @(posedge clk); #1;
    if (phase0) begin
      w = 0;
      do begin @(negedge clk); w++; end while (!mif.req_ready && w < 8);
      @(posedge clk); #1;
    end
    mif.req_valid = 1'b1;
    mif.req_op    = op;
    mif.req_addr  = addr;
    mif.req_wdata = wdata;
    if (phase0) begin
      @(negedge clk);
      chk("phase0_ready_low", 128'(mif.req_ready), 128'(1'b0));
    end
    w = 0;
    do begin @(negedge clk); w++; end while (!mif.req_ready && w < 8);
    chk("accept_ready", 128'(mif.req_ready), 128'(1'b1));
    if (phase0) chk("phase0_wait_one", 128'(w), 128'(1));
    @(posedge clk); #1;
    if (!hold) mif.req_valid = 1'b0;
    else begin
      mif.req_op    = 3'($urandom_range(0, 7));
      mif.req_addr  = $urandom;
      mif.req_wdata = $urandom;
    end

    bad = (op == 3'b111) || (addr >= 32'h1000);
    a   = addr % 4096;
    exp_rdata = (op <= 3'd4) ? ref_ext(op, ref_word(a)) : 32'h0;
    exp_mr    = (op <= 3'd4);
    exp_mw    = (op == 3'd5) ? 2'd1 : (op == 3'd6) ? 2'd3 : 2'd0;
    exp_drv   = (op == 3'd5) || (op == 3'd6);
    exp_dout  = (op == 3'd5) ? wdata : (op == 3'd6) ? (wdata % 256) : 32'h0;

    if (bad) begin
      @(negedge clk);
      chk("err_resp",
          128'({mif.resp_valid, mif.resp_err, mif.resp_rdata, mif.Memread, mif.Memwrite, mif.bus_drive}),
          128'({1'b1, 1'b1, 32'h0, 1'b0, 2'd0, 1'b0}));
    end else begin
      for (int k = 1; k <= ACC; k++) begin
        @(negedge clk);
        chk($sformatf("window_op%0d_c%0d", op, k),
            128'({mif.Memread, mif.Memwrite, mif.bus_drive, mif.Addrin,
                  (mif.bus_drive ? mif.bus_dout : 32'h0), mif.resp_valid, mif.req_ready}),
            128'({exp_mr, exp_mw, exp_drv, 12'(a), exp_dout, 1'b0, 1'b0}));
      end
      @(negedge clk);
      chk($sformatf("resp_op%0d", op),
          128'({mif.resp_valid, mif.resp_err, mif.resp_rdata, mif.Memread, mif.Memwrite, mif.bus_drive}),
          128'({1'b1, 1'b0, exp_rdata, 1'b0, 2'd0, 1'b0}));
      if (op == 3'd5) begin
        for (int j = 0; j < 4; j++) ref_mem[(a + j) % 4096] = (wdata >> (8 * j)) % 256;
      end else if (op == 3'd6) begin
        ref_mem[a] = wdata % 256;
      end
    end
    if (hold) mif.req_valid = 1'b0;
    @(negedge clk);
    chk("idle_after",
        128'({mif.req_ready, mif.resp_valid, mif.resp_err, mif.resp_rdata,
              mif.Memread, mif.Memwrite, mif.bus_drive}),
        128'({1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] raddr;
    int          w;
    for (int i = 0; i < 4096; i++) ref_mem[i] = (i * 37 + 11) % 256;
    rst           = 1'b1;
    mif.req_valid = 1'b0;
    mif.req_op    = 3'd0;
    mif.req_addr  = 32'h0;
    mif.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        128'({mif.req_ready, mif.resp_valid, mif.resp_err, mif.resp_rdata, mif.Memread,
              mif.Memwrite, mif.Addrin, mif.bus_dout, mif.bus_drive}),
        128'(0));
    @(negedge clk);
    chk("ready_phase1_after_reset", 128'(mif.req_ready), 128'(1'b1));

    // Directed loads and stores.
    do_req(3'd5, 32'h004, 32'hDEADBEEF, 0, 0);
    do_req(3'd0, 32'h004, 32'h0, 0, 0);
    do_req(3'd6, 32'h005, 32'h00000080, 0, 0);
    do_req(3'd1, 32'h005, 32'h0, 0, 0);
    do_req(3'd2, 32'h005, 32'h0, 0, 0);
    do_req(3'd5, 32'h008, 32'h0000F00D, 0, 0);
    do_req(3'd3, 32'h008, 32'h0, 0, 0);
    do_req(3'd4, 32'h008, 32'h0, 0, 0);
    do_req(3'd0, 32'h006, 32'h0, 0, 0);
    // Out-of-range and illegal-opcode rejections.
    do_req(3'd0, 32'h00001000, 32'h0, 0, 0);
    do_req(3'd7, 32'h004, 32'h12345678, 0, 0);
    // Request raised on phase 0, held and scrambled through the access.
    do_req(3'd0, 32'h004, 32'h0, 1, 1);
    do_req(3'd6, 32'h00B, 32'h5A5A5A3C, 1, 1);

    // Reset during the second cycle of a word store.
    @(posedge clk); #1;
    mif.req_valid = 1'b1;
    mif.req_op    = 3'd5;
    mif.req_addr  = 32'h100;
    mif.req_wdata = 32'hCAFEF00D;
    w = 0;
    do begin @(negedge clk); w++; end while (!mif.req_ready && w < 8);
    chk("abort_accept", 128'(mif.req_ready), 128'(1'b1));
    @(posedge clk); #1 mif.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_window_start", 128'({mif.Memwrite, mif.bus_drive}), 128'({2'd1, 1'b1}));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_cleared",
        128'({mif.Memwrite, mif.bus_drive, mif.Memread, mif.resp_valid, mif.req_ready}), 128'(0));
    @(negedge clk);
    chk("abort_ready_returns", 128'({mif.req_ready, mif.resp_valid}), 128'({1'b1, 1'b0}));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_resp", 128'({mif.resp_valid, mif.Memwrite, mif.bus_drive}), 128'(0));
    end

    // Randomized traffic confined away from the aborted store's bytes.
    for (int i = 0; i < 24; i++) begin
      rop   = 3'($urandom_range(0, 7));
      raddr = 32'h200 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) raddr[31:12] = 20'($urandom_range(1, 20'hFFFFF));
      do_req(rop, raddr, $urandom, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
